// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM stage
// and a multi-cycle data RAM. Read hits return combinationally; misses and writes stall.
module data_cache #(
    parameter int INDEX_WIDTH = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_ren,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_din,
    output logic [31:0]          cpu_dout,
    output logic                 cpu_stall,
    output logic                 mem_ren,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_din,
    input  logic [31:0]          mem_dout,
    input  logic                 mem_ack,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt
);
    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = 32 - INDEX_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    state_t               state_q, state_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [TAG_W-1:0]     tag_d  [LINES];
    logic [31:0]          data_q [LINES];
    logic [31:0]          data_d [LINES];
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          din_q, din_d;
    logic [31:0]          resp_data_q, resp_data_d;
    logic                 resp_rd_q, resp_rd_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    logic [INDEX_WIDTH-1:0] cpu_idx, lat_idx;
    logic [TAG_W-1:0]       cpu_tag, lat_tag;
    logic                   cpu_hit, lat_hit, rd_hit, in_resp;

    assign cpu_idx = cpu_addr[INDEX_WIDTH-1:0];
    assign cpu_tag = cpu_addr[31:INDEX_WIDTH];
    assign lat_idx = addr_q[INDEX_WIDTH-1:0];
    assign lat_tag = addr_q[31:INDEX_WIDTH];
    assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);
    // A store takes priority, so ren with we never counts as a read hit.
    assign rd_hit  = (state_q == S_IDLE) && cpu_ren && !cpu_we && cpu_hit;
    assign in_resp = (state_q == S_RESP);

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        addr_d      = addr_q;
        din_d       = din_q;
        resp_data_d = resp_data_q;
        resp_rd_d   = resp_rd_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_we) begin
                    addr_d  = cpu_addr;
                    din_d   = cpu_din;
                    state_d = S_WR;
                end else if (cpu_ren) begin
                    if (cpu_hit) begin
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_ONE;
                    end else begin
                        addr_d  = cpu_addr;
                        state_d = S_RD;
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_ONE;
                    end
                end
            end
            S_RD: begin
                if (mem_ack) begin
                    valid_d[lat_idx] = 1'b1;
                    tag_d[lat_idx]   = lat_tag;
                    data_d[lat_idx]  = mem_dout;
                    resp_data_d      = mem_dout;
                    resp_rd_d        = 1'b1;
                    state_d          = S_RESP;
                end
            end
            S_WR: begin
                if (mem_ack) begin
                    // No write-allocate: only an already-resident line is refreshed.
                    if (lat_hit) data_d[lat_idx] = din_q;
                    resp_rd_d = 1'b0;
                    state_d   = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            resp_data_q <= '0;
            resp_rd_q   <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            resp_data_q <= resp_data_d;
            resp_rd_q   <= resp_rd_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Tag and data storage need no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    always_comb begin
        cpu_dout = '0;
        if (!rst) begin
            if (rd_hit) cpu_dout = data_q[cpu_idx];
            else if (in_resp && resp_rd_q) cpu_dout = resp_data_q;
        end
    end

    assign cpu_stall = !rst && (cpu_ren || cpu_we) && !(rd_hit || in_resp);
    assign mem_ren   = (state_q == S_RD);
    assign mem_we    = (state_q == S_WR);
    assign mem_addr  = addr_q;
    assign mem_din   = din_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed scenarios plus random traffic, checked every cycle
// against an address-keyed cache model and a RAM model held in associative arrays.
module tb_data_cache;
    localparam int IW = 3;
    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_ren, cpu_we;
    logic [31:0]   cpu_addr, cpu_din, cpu_dout;
    logic          cpu_stall, mem_ren, mem_we;
    logic [31:0]   mem_addr, mem_din, mem_dout;
    logic          mem_ack;
    logic [CW-1:0] hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    data_cache #(.INDEX_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .cpu_ren(cpu_ren), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall), .mem_ren(mem_ren),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Model: RAM contents and the set of cached addresses (at most one per index).
    logic [31:0] ram_m   [logic [31:0]];
    logic [31:0] cache_m [logic [31:0]];
    int          hit_m, miss_m;

    logic        exp_stall, exp_mem_ren, exp_mem_we;
    logic [31:0] exp_dout, exp_addr, exp_din;
    bit          chk_en = 1'b0;
    logic [31:0] last_dout;

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (ram_m.exists(a)) return ram_m[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? v : v + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_fill(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] victims[$];
        foreach (cache_m[k]) if (k[IW-1:0] == a[IW-1:0]) victims.push_back(k);
        foreach (victims[i]) cache_m.delete(victims[i]);
        cache_m[a] = d;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
            check("cpu_dout", cpu_dout, exp_dout);
            check("mem_ren", 32'(mem_ren), 32'(exp_mem_ren));
            check("mem_we", 32'(mem_we), 32'(exp_mem_we));
            if (exp_mem_ren || exp_mem_we) check("mem_addr", mem_addr, exp_addr);
            if (exp_mem_we) check("mem_din", mem_din, exp_din);
            check("hit_cnt", 32'(hit_cnt), hit_m);
            check("miss_cnt", 32'(miss_cnt), miss_m);
        end
    end

    task automatic clear_exp();
        exp_stall   = 1'b0;
        exp_dout    = '0;
        exp_mem_ren = 1'b0;
        exp_mem_we  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // One CPU access, starting and ending 1ns after a rising edge; the RAM answers after lat cycles.
    task automatic do_access(input bit ren, input bit we, input logic [31:0] a,
                             input logic [31:0] d, input int lat);
        logic [31:0] rdata;
        cpu_ren  = ren;
        cpu_we   = we;
        cpu_addr = a;
        cpu_din  = d;
        if (!we && ren && cache_m.exists(a)) begin
            exp_stall = 1'b0;
            exp_dout  = cache_m[a];
            #3 last_dout = cpu_dout;
            step();
            hit_m = sat_inc(hit_m);
        end else if (ren || we) begin
            exp_stall = 1'b1;
            exp_dout  = '0;
            #3 last_dout = cpu_dout;
            step();
            if (!we) miss_m = sat_inc(miss_m);
            exp_mem_ren = !we;
            exp_mem_we  = we;
            exp_addr    = a;
            exp_din     = d;
            idle(lat);
            rdata    = we ? $urandom : ram_rd(a);
            mem_ack  = 1'b1;
            mem_dout = rdata;
            step();
            mem_ack = 1'b0;
            if (we) begin
                ram_m[a] = d;
                if (cache_m.exists(a)) cache_m[a] = d;
            end else begin
                model_fill(a, rdata);
            end
            exp_mem_ren = 1'b0;
            exp_mem_we  = 1'b0;
            exp_stall   = 1'b0;
            exp_dout    = we ? 32'h0 : rdata;
            #3 last_dout = cpu_dout;
            step();
        end else begin
            step();
        end
        cpu_ren = 1'b0;
        cpu_we  = 1'b0;
        clear_exp();
    endtask

    initial begin
        int          op;
        logic [31:0] a;
        rst = 1'b1;
        cpu_ren = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        mem_ack = 1'b0; mem_dout = '0;
        hit_m = 0; miss_m = 0; exp_addr = '0; exp_din = '0; last_dout = '0;
        clear_exp();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_din", mem_din, 32'h0);

        // Cold read miss then hit on the same word
        do_access(1'b1, 1'b0, 32'h3, 32'h0, 2);
        check("t1_dout", last_dout, 32'h0003_FFFC);
        check("t1_miss", 32'(miss_cnt), 32'd1);
        idle(1);
        do_access(1'b1, 1'b0, 32'h3, 32'h0, 0);
        check("t2_dout", last_dout, 32'h0003_FFFC);
        check("t2_hit", 32'(hit_cnt), 32'd1);

        // Write hit updates the line
        do_access(1'b0, 1'b1, 32'h3, 32'hDEAD_BEEF, 3);
        do_access(1'b1, 1'b0, 32'h3, 32'h0, 0);
        check("t3_dout", last_dout, 32'hDEAD_BEEF);
        check("t3_hit", 32'(hit_cnt), 32'd2);

        // Write miss to a conflicting tag leaves the line alone
        do_access(1'b0, 1'b1, 32'hB, 32'h1234_5678, 1);
        do_access(1'b1, 1'b0, 32'h3, 32'h0, 0);
        check("t4_old_tag", last_dout, 32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 32'hB, 32'h0, 2);
        check("t4_new_miss", last_dout, 32'h1234_5678);
        check("t4_miss", 32'(miss_cnt), 32'd2);

        // Simultaneous ren and we is a write
        do_access(1'b1, 1'b1, 32'h5, 32'h0000_0055, 1);
        check("t5_hit", 32'(hit_cnt), 32'd3);
        check("t5_miss", 32'(miss_cnt), 32'd2);

        // Reset in the middle of a read miss, then a stray ack
        cpu_ren = 1'b1; cpu_addr = 32'h13;
        exp_stall = 1'b1;
        step();
        miss_m = sat_inc(miss_m);
        exp_mem_ren = 1'b1; exp_addr = 32'h13;
        step();
        chk_en = 1'b0;
        rst = 1'b1;
        #3 check("t6_rst_stall", 32'(cpu_stall), 32'd0);
        step();
        rst = 1'b0; cpu_ren = 1'b0;
        cache_m.delete();
        hit_m = 0; miss_m = 0;
        clear_exp();
        chk_en = 1'b1;
        check("t6_mem_ren", 32'(mem_ren), 32'd0);
        check("t6_mem_addr", mem_addr, 32'h0);
        mem_ack = 1'b1; mem_dout = 32'hBAD0_BAD0;
        step();
        mem_ack = 1'b0;
        do_access(1'b1, 1'b0, 32'hB, 32'h0, 1);
        check("t6_invalid", 32'(miss_cnt), 32'd1);
        check("t6_dout", last_dout, 32'h1234_5678);

        // Random traffic over a few conflicting tags plus scattered addresses
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 23));
            do_access(op <= 4 || op == 9, op >= 5, a, $urandom, $urandom_range(0, 4));
            idle($urandom_range(0, 2));
        end

        // Counter saturation
        do_access(1'b1, 1'b0, 32'h1, 32'h0, 0);
        for (int n = 0; n < 300; n++) do_access(1'b1, 1'b0, 32'h1, 32'h0, 0);
        check("sat_hit", 32'(hit_cnt), 32'd255);
        for (int n = 0; n < 300; n++) do_access(1'b1, 1'b0, (n % 2 == 0) ? 32'h2 : 32'hA, 32'h0, 0);
        check("sat_miss", 32'(miss_cnt), 32'd255);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
